// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write port of the boot loader.
//   in_valid / in_data / in_ready : byte stream, a byte moves when valid & ready
//   imem_we / imem_addr / imem_din : word write port into the instruction memory
// modport master : stream source and memory side (drives bytes, observes writes)
// modport slave  : the loader itself
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 10
) ();
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_din;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_din
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_din
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the instruction memory.
// Frame: len[7:0], len[15:8], len words of big-endian data bytes, XOR checksum of data bytes.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   start_i          : one-cycle pulse, begins a load session from IDLE/DONE/ERR
//   bus_io           : byte stream in, instruction-memory write port out
//   cpu_hold_o       : keeps the core in reset until a good image is loaded
//   done_o, error_o  : sticky session result flags
//   words_written_o  : words written in the current session
module imem_loader #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    imem_loader_if.slave      bus_io,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ADDR_W:0]   words_written_o
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        StIdle, StLenLo, StLenHi, StData, StCsum, StDone, StErr
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [23:0]       word_q, word_d;       // first three bytes of the word in progress
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       din_q, din_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              hold_q, hold_d;

    logic active;
    logic accept;
    logic [15:0] len_full;

    assign active   = (state_q == StLenLo) || (state_q == StLenHi) ||
                      (state_q == StData)  || (state_q == StCsum);
    assign accept   = bus_io.in_valid & active;
    assign len_full = {bus_io.in_data, len_q[7:0]};

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        csum_d     = csum_q;
        wr_cnt_d   = wr_cnt_q;
        tmo_d      = tmo_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        din_d      = din_q;
        done_d     = done_q;
        error_d    = error_q;
        hold_d     = hold_q;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start_i) begin
                    state_d    = StLenLo;
                    hold_d     = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    wr_cnt_d   = '0;
                    csum_d     = '0;
                    word_d     = '0;
                    byte_cnt_d = '0;
                    len_d      = '0;
                    tmo_d      = '0;
                end
            end
            StLenLo: begin
                if (accept) begin
                    len_d[7:0] = bus_io.in_data;
                    state_d    = StLenHi;
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_d[15:8] = bus_io.in_data;
                    if (32'(len_full) > DEPTH) begin
                        state_d = StErr;
                        error_d = 1'b1;
                    end else if (len_full == 16'd0) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    csum_d = csum_q ^ bus_io.in_data;
                    if (byte_cnt_q == 2'd3) begin
                        din_d      = {word_q, bus_io.in_data};
                        addr_d     = wr_cnt_q[ADDR_W-1:0];
                        we_d       = 1'b1;
                        wr_cnt_d   = wr_cnt_q + 1'b1;
                        byte_cnt_d = '0;
                        if (32'(wr_cnt_q) + 32'd1 == 32'(len_q)) begin
                            state_d = StCsum;
                        end
                    end else begin
                        word_d     = {word_q[15:0], bus_io.in_data};
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            StCsum: begin
                if (accept) begin
                    if (bus_io.in_data == csum_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = StErr;
                        error_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // Idle-gap watchdog; a half-built word is simply dropped on abort.
        if (active) begin
            if (accept) begin
                tmo_d = '0;
            end else if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
                tmo_d   = '0;
                state_d = StErr;
                error_d = 1'b1;
            end else begin
                tmo_d = tmo_q + TmoW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            len_q      <= '0;
            word_q     <= '0;
            byte_cnt_q <= '0;
            csum_q     <= '0;
            wr_cnt_q   <= '0;
            tmo_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            hold_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
            csum_q     <= csum_d;
            wr_cnt_q   <= wr_cnt_d;
            tmo_q      <= tmo_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            done_q     <= done_d;
            error_q    <= error_d;
            hold_q     <= hold_d;
        end
    end

    assign bus_io.in_ready  = active;
    assign bus_io.imem_we   = we_q;
    assign bus_io.imem_addr = addr_q;
    assign bus_io.imem_din  = din_q;
    assign cpu_hold_o       = hold_q;
    assign done_o           = done_q;
    assign error_o          = error_q;
    assign words_written_o  = wr_cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the stimulus thread and
// checked by an independent monitor on every imem_we pulse.
module tb_imem_loader;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned TMO    = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            cpu_hold;
    logic            done;
    logic            error;
    logic [ADDR_W:0] words_written;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start),
        .bus_io          (bus),
        .cpu_hold_o      (cpu_hold),
        .done_o          (done),
        .error_o         (error),
        .words_written_o (words_written)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  bp    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every write pulse must match the head of the expected queue.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (bus.imem_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got addr %h data %h, required no write",
                             bus.imem_addr, bus.imem_din);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(bus.imem_addr), 32'(e.addr));
                    check("wr_data", bus.imem_din, e.data);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        @(negedge clk);
        if (bp) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (bus.in_ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL in_ready_wait: got in_ready=%b after 50 cycles, required 1",
                     bus.in_ready);
        end else begin
            @(posedge clk);
        end
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic check_status(input logic d, input logic e, input logic h, input int ww);
        @(negedge clk);
        check("done", 32'(done), 32'(d));
        check("error", 32'(error), 32'(e));
        check("cpu_hold", 32'(cpu_hold), 32'(h));
        check("words_written", 32'(words_written), 32'(ww));
        check("in_ready_idle", 32'(bus.in_ready), 32'd0);
        check("pending_writes", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_imem_we"}, 32'(bus.imem_we), 32'd0);
        check({tag, "_imem_addr"}, 32'(bus.imem_addr), 32'd0);
        check({tag, "_imem_din"}, bus.imem_din, 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_words_written"}, 32'(words_written), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        rst          = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Basic load. XOR of 11 22 33 44 AA BB CC DD is 0x44.
        do_start();
        @(negedge clk);
        check("start_hold", 32'(cpu_hold), 32'd1);
        check("start_ready", 32'(bus.in_ready), 32'd1);
        expect_wr(10'd0, 32'h11223344);
        expect_wr(10'd1, 32'hAABBCCDD);
        send_byte(8'h02); send_byte(8'h00);
        send_word(32'h11223344); send_word(32'hAABBCCDD);
        send_byte(8'h44);
        check_status(1'b1, 1'b0, 1'b0, 2);

        // Bad checksum: words still land, image rejected.
        do_start();
        expect_wr(10'd0, 32'h11223344);
        expect_wr(10'd1, 32'hAABBCCDD);
        send_byte(8'h02); send_byte(8'h00);
        send_word(32'h11223344); send_word(32'hAABBCCDD);
        send_byte(8'h5A);
        check_status(1'b0, 1'b1, 1'b1, 2);
        check("hold_addr", 32'(bus.imem_addr), 32'd1);
        check("hold_din", bus.imem_din, 32'hAABBCCDD);
        check("hold_we", 32'(bus.imem_we), 32'd0);

        // Oversize length 1025.
        do_start();
        send_byte(8'h01); send_byte(8'h04);
        check_status(1'b0, 1'b1, 1'b1, 0);
        repeat (3) @(negedge clk);
        check("oversize_ready", 32'(bus.in_ready), 32'd0);

        // Zero length with a bubble before every byte.
        do_start();
        bp = 1'b1;
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        bp = 1'b0;
        check_status(1'b1, 1'b0, 1'b0, 0);

        // Timeout after two data bytes of a one-word frame.
        do_start();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB);
        cyc = 0;
        while (error !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1 cyc++;
        end
        check("timeout_cycles", 32'(cyc), 32'(TMO));
        check_status(1'b0, 1'b1, 1'b1, 0);

        // Recovery: 12^34^56^78 = 0x08.
        do_start();
        expect_wr(10'd0, 32'h12345678);
        send_byte(8'h01); send_byte(8'h00);
        send_word(32'h12345678);
        send_byte(8'h08);
        check_status(1'b1, 1'b0, 1'b0, 1);

        // Reset after the third data byte, then a full reload from address 0.
        do_start();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        do_start();
        expect_wr(10'd0, 32'h11223344);
        expect_wr(10'd1, 32'hAABBCCDD);
        send_byte(8'h02); send_byte(8'h00);
        send_word(32'h11223344); send_word(32'hAABBCCDD);
        send_byte(8'h44);
        check_status(1'b1, 1'b0, 1'b0, 2);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
